reg_writeback_queue: RTL and testbench

- Write-side initiator for the CPU's 16x16 register file. Accepts register-write requests from two producers, the ALU and memory load, and queues them in order.
- Drains one request per cycle onto the register file write port (Write_Reg/Write_Data/RegWrite).
- Provides combinational forwarding of pending, not-yet-written values to the read stage.

---
 rtl/cpu_pkg.sv | 14 +
 rtl/wb_fwd_lookup.sv | 36 +++
 rtl/reg_writeback_queue.sv | 114 +++++++++++
 tb/tb_reg_writeback_queue.sv | 244 ++++++++++++++++++++++++
 4 files changed

// File: rtl/cpu_pkg.sv
// Shared CPU definitions: register file geometry and the write-back request type.
package cpu_pkg;

    localparam int unsigned DW       = 16;
    localparam int unsigned AW       = 4;
    localparam int unsigned NUM_REGS = 16;

    // One pending register-file write.
    typedef struct packed {
        logic [AW-1:0] addr;
        logic [DW-1:0] data;
    } wb_req_t;

endpackage

// File: rtl/wb_fwd_lookup.sv
// Youngest-match search over the valid region of the write-back queue.
// Entries live at head, head+1, ... head+count-1 (mod DEPTH); the last
// match in that walk is the youngest and wins.
module wb_fwd_lookup
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4
) (
    input  wb_req_t [DEPTH-1:0]         entries,
    input  logic [$clog2(DEPTH)-1:0]    head,
    input  logic [$clog2(DEPTH):0]      count,
    input  logic [AW-1:0]               addr,
    output logic                        hit,
    output logic [DW-1:0]               data
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    logic [PW-1:0] idx;

    // Walk oldest to youngest so later matches override earlier ones.
    always_comb begin
        hit  = 1'b0;
        data = '0;
        idx  = '0;
        for (int unsigned i = 0; i < DEPTH; i++) begin
            idx = head + PW'(i);
            if ((CW'(i) < count) && (entries[idx].addr == addr)) begin
                hit  = 1'b1;
                data = entries[idx].data;
            end
        end
    end

endmodule

// File: rtl/reg_writeback_queue.sv
// In-order write-back queue between the ALU / load producers and the
// register file write port, with forwarding of not-yet-committed values.
module reg_writeback_queue
    import cpu_pkg::*;
#(
    parameter int unsigned DEPTH = 4,
    parameter int unsigned DW    = cpu_pkg::DW,
    parameter int unsigned AW    = cpu_pkg::AW
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     mem_valid,
    input  logic [AW-1:0]            mem_addr,
    input  logic [DW-1:0]            mem_data,
    output logic                     mem_ready,
    input  logic                     alu_valid,
    input  logic [AW-1:0]            alu_addr,
    input  logic [DW-1:0]            alu_data,
    output logic                     alu_ready,
    output logic                     wb_we,
    output logic [AW-1:0]            wb_addr,
    output logic [DW-1:0]            wb_data,
    input  logic [AW-1:0]            fwd_addr1,
    input  logic [AW-1:0]            fwd_addr2,
    output logic                     fwd_hit1,
    output logic [DW-1:0]            fwd_data1,
    output logic                     fwd_hit2,
    output logic [DW-1:0]            fwd_data2,
    output logic [$clog2(DEPTH):0]   count,
    output logic                     empty
);

    localparam int unsigned PW = $clog2(DEPTH);
    localparam int unsigned CW = PW + 1;

    wb_req_t [DEPTH-1:0] entries_q;
    logic [PW-1:0]       head_q, head_d;
    logic [PW-1:0]       tail_q, tail_d;
    logic [PW-1:0]       tail_alu;
    logic [CW-1:0]       count_q, count_d;
    logic [CW-1:0]       free;
    logic                push_mem, push_alu, pop;

    assign count = count_q;
    assign empty = (count_q == '0);

    // Credit comes from the registered count only; a same-cycle pop frees nothing.
    always_comb begin
        free      = CW'(DEPTH) - count_q;
        mem_ready = (free >= CW'(1));
        alu_ready = mem_valid ? (free >= CW'(2)) : (free >= CW'(1));
        push_mem  = mem_valid & mem_ready;
        push_alu  = alu_valid & alu_ready;
        // The register file commits on the negedge, so the head always retires.
        pop       = ~empty;
        tail_alu  = tail_q + PW'(push_mem);
        tail_d    = tail_q + PW'(push_mem) + PW'(push_alu);
        head_d    = head_q + PW'(pop);
        count_d   = count_q + CW'(push_mem) + CW'(push_alu) - CW'(pop);
    end

    // Pointer and occupancy state; reset drops everything pending.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // Entry storage; the load lands first so the ALU result is the younger entry.
    always_ff @(posedge clk) begin
        if (push_mem) begin
            entries_q[tail_q] <= '{addr: mem_addr, data: mem_data};
        end
        if (push_alu) begin
            entries_q[tail_alu] <= '{addr: alu_addr, data: alu_data};
        end
    end

    // Register file write port driven straight from the head entry.
    always_comb begin
        wb_we   = ~empty;
        wb_addr = empty ? '0 : entries_q[head_q].addr;
        wb_data = empty ? '0 : entries_q[head_q].data;
    end

    wb_fwd_lookup #(
        .DEPTH (DEPTH)
    ) u_fwd1 (
        .entries (entries_q),
        .head    (head_q),
        .count   (count_q),
        .addr    (fwd_addr1),
        .hit     (fwd_hit1),
        .data    (fwd_data1)
    );

    wb_fwd_lookup #(
        .DEPTH (DEPTH)
    ) u_fwd2 (
        .entries (entries_q),
        .head    (head_q),
        .count   (count_q),
        .addr    (fwd_addr2),
        .hit     (fwd_hit2),
        .data    (fwd_data2)
    );

endmodule

// File: tb/tb_reg_writeback_queue.sv
// Directed bench for reg_writeback_queue with a negedge-commit register file model.
module tb_reg_writeback_queue;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_valid, alu_valid;
    logic [3:0]  mem_addr, alu_addr;
    logic [15:0] mem_data, alu_data;
    logic        mem_ready, alu_ready;
    logic        wb_we;
    logic [3:0]  wb_addr;
    logic [15:0] wb_data;
    logic [3:0]  fwd_addr1, fwd_addr2;
    logic        fwd_hit1, fwd_hit2;
    logic [15:0] fwd_data1, fwd_data2;
    logic [2:0]  count;
    logic        empty;

    int checks = 0;
    int errors = 0;

    logic [15:0] rf     [16];
    logic [15:0] ref_rf [16];

    reg_writeback_queue #(
        .DEPTH (4),
        .DW    (16),
        .AW    (4)
    ) dut (
        .clk       (clk),
        .rst_n     (rst_n),
        .mem_valid (mem_valid),
        .mem_addr  (mem_addr),
        .mem_data  (mem_data),
        .mem_ready (mem_ready),
        .alu_valid (alu_valid),
        .alu_addr  (alu_addr),
        .alu_data  (alu_data),
        .alu_ready (alu_ready),
        .wb_we     (wb_we),
        .wb_addr   (wb_addr),
        .wb_data   (wb_data),
        .fwd_addr1 (fwd_addr1),
        .fwd_addr2 (fwd_addr2),
        .fwd_hit1  (fwd_hit1),
        .fwd_data1 (fwd_data1),
        .fwd_hit2  (fwd_hit2),
        .fwd_data2 (fwd_data2),
        .count     (count),
        .empty     (empty)
    );

    always #5 clk = ~clk;

    // Register file commits on the falling edge.
    always @(negedge clk) begin
        if (wb_we) rf[wb_addr] <= wb_data;
    end

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    initial begin
        int wi;
        int cycles;

        rst_n     = 1'b0;
        mem_valid = 1'b0; mem_addr = '0; mem_data = '0;
        alu_valid = 1'b0; alu_addr = '0; alu_data = '0;
        fwd_addr1 = '0;   fwd_addr2 = '0;

        // Reset state
        #2;
        check("rst_count", 32'(count), 0);
        check("rst_empty", 32'(empty), 1);
        check("rst_wb_we", 32'(wb_we), 0);
        check("rst_wb_addr", 32'(wb_addr), 0);
        check("rst_wb_data", 32'(wb_data), 0);
        check("rst_mem_ready", 32'(mem_ready), 1);
        check("rst_alu_ready", 32'(alu_ready), 1);
        check("rst_hit1", 32'(fwd_hit1), 0);
        check("rst_data2", 32'(fwd_data2), 0);
        repeat (2) @(posedge clk);
        #1 rst_n = 1'b1;
        step();
        check("idle_empty", 32'(empty), 1);

        // Single ALU write
        alu_valid = 1'b1; alu_addr = 4'd3; alu_data = 16'h1234;
        #1 check("single_alu_ready", 32'(alu_ready), 1);
        step();
        alu_valid = 1'b0;
        check("single_we", 32'(wb_we), 1);
        check("single_addr", 32'(wb_addr), 3);
        check("single_data", 32'(wb_data), 32'h1234);
        check("single_count", 32'(count), 1);
        @(negedge clk);
        #1 check("single_rf3", 32'(rf[3]), 32'h1234);
        step();
        check("single_we_off", 32'(wb_we), 0);
        check("single_empty", 32'(empty), 1);
        check("single_data_zero", 32'(wb_data), 0);

        // Dual push to the same register: load first, ALU younger
        mem_valid = 1'b1; mem_addr = 4'd5; mem_data = 16'hAAAA;
        alu_valid = 1'b1; alu_addr = 4'd5; alu_data = 16'hBBBB;
        fwd_addr1 = 4'd5;
        #1;
        check("dual_mem_ready", 32'(mem_ready), 1);
        check("dual_alu_ready", 32'(alu_ready), 1);
        check("dual_incoming_not_fwd", 32'(fwd_hit1), 0);
        step();
        mem_valid = 1'b0; alu_valid = 1'b0;
        check("dual_count2", 32'(count), 2);
        check("dual_wb0", 32'(wb_data), 32'hAAAA);
        check("dual_fwd_hit_2p", 32'(fwd_hit1), 1);
        check("dual_fwd_2p", 32'(fwd_data1), 32'hBBBB);
        step();
        check("dual_wb1", 32'(wb_data), 32'hBBBB);
        check("dual_fwd_1p", 32'(fwd_data1), 32'hBBBB);
        step();
        check("dual_drained_we", 32'(wb_we), 0);
        check("dual_fwd_miss", 32'(fwd_hit1), 0);
        check("dual_fwd_miss_data", 32'(fwd_data1), 0);
        check("dual_rf5", 32'(rf[5]), 32'hBBBB);

        // Forward port 2 hit and miss
        alu_valid = 1'b1; alu_addr = 4'd7; alu_data = 16'h00FF;
        step();
        alu_valid = 1'b0;
        fwd_addr2 = 4'd7;
        #1;
        check("p2_hit", 32'(fwd_hit2), 1);
        check("p2_data", 32'(fwd_data2), 32'h00FF);
        fwd_addr2 = 4'd8;
        #1;
        check("p2_miss_hit", 32'(fwd_hit2), 0);
        check("p2_miss_data", 32'(fwd_data2), 0);
        step();
        check("p2_empty", 32'(empty), 1);

        // Fill to three entries, then exercise load priority on the last slot
        mem_valid = 1'b1; mem_addr = 4'd1; mem_data = 16'h0011;
        alu_valid = 1'b1; alu_addr = 4'd2; alu_data = 16'h0022;
        step();
        check("full_count2", 32'(count), 2);
        mem_addr = 4'd3; mem_data = 16'h0033;
        alu_addr = 4'd4; alu_data = 16'h0044;
        #1 check("full_alu_ready_free2", 32'(alu_ready), 1);
        step();
        check("full_count3", 32'(count), 3);
        check("full_head2", 32'(wb_addr), 2);
        mem_valid = 1'b0;
        alu_addr  = 4'd6; alu_data = 16'h0066;
        #1 check("full_alu_only_ready", 32'(alu_ready), 1);
        mem_valid = 1'b1; mem_addr = 4'd5; mem_data = 16'h0055;
        fwd_addr1 = 4'd6;
        #1;
        check("full_mem_ready", 32'(mem_ready), 1);
        check("full_alu_blocked", 32'(alu_ready), 0);
        step();
        mem_valid = 1'b0; alu_valid = 1'b0;
        check("full_count_hold", 32'(count), 3);
        check("full_head3", 32'(wb_addr), 3);
        check("full_alu_dropped", 32'(fwd_hit1), 0);
        fwd_addr1 = 4'd5;
        #1;
        check("full_mem_fwd_hit", 32'(fwd_hit1), 1);
        check("full_mem_fwd_data", 32'(fwd_data1), 32'h0055);
        step();
        check("full_head4", 32'(wb_addr), 4);
        step();
        check("full_head5", 32'(wb_addr), 5);
        check("full_head5_data", 32'(wb_data), 32'h0055);
        step();
        check("full_drained", 32'(empty), 1);

        // Reset in the middle of traffic with three entries pending
        mem_valid = 1'b1; mem_addr = 4'd8;  mem_data = 16'h0088;
        alu_valid = 1'b1; alu_addr = 4'd9;  alu_data = 16'h0099;
        step();
        mem_addr = 4'd10; mem_data = 16'h00A0;
        alu_addr = 4'd11; alu_data = 16'h00B0;
        step();
        mem_valid = 1'b0; alu_valid = 1'b0;
        fwd_addr1 = 4'd10;
        check("mid_count3", 32'(count), 3);
        #1 rst_n = 1'b0;
        #1;
        check("mid_rst_count", 32'(count), 0);
        check("mid_rst_we", 32'(wb_we), 0);
        check("mid_rst_hit1", 32'(fwd_hit1), 0);
        check("mid_rst_empty", 32'(empty), 1);
        @(posedge clk);
        #1 rst_n = 1'b1;
        for (int k = 0; k < 3; k++) begin
            step();
            check("post_rst_no_write", 32'(wb_we), 0);
        end

        // Wrap-around stream: ALU held valid, random load traffic alongside
        for (int r = 0; r < 16; r++) ref_rf[r] = '0;
        wi = 0;
        cycles = 0;
        while (wi < 10 && cycles < 100) begin
            alu_valid = 1'b1;
            alu_addr  = 4'(wi);
            alu_data  = 16'(32'h100 + wi);
            mem_valid = 1'($urandom_range(0, 1));
            mem_addr  = 4'($urandom_range(0, 9));
            mem_data  = 16'($urandom);
            #1;
            if (mem_valid && mem_ready) ref_rf[mem_addr] = mem_data;
            if (alu_ready) begin
                ref_rf[wi] = alu_data;
                wi++;
            end
            check("wrap_count_le4", 32'(count <= 3'd4), 1);
            step();
            cycles++;
        end
        mem_valid = 1'b0; alu_valid = 1'b0;
        check("wrap_all_accepted", 32'(wi), 10);
        repeat (6) step();
        check("wrap_empty", 32'(empty), 1);
        for (int r = 0; r < 10; r++) begin
            check($sformatf("wrap_rf%0d", r), 32'(rf[r]), 32'(ref_rf[r]));
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
